// File: rtl/codificador_teclado.sv
// codificador_teclado: 4x4 keypad column scanner with debounce, reports 4*row+col.
module codificador_teclado #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Filas,
    output logic [3:0] Columnas,
    output logic [3:0] Codigo,
    output logic       Valida,
    output logic       Presionada
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE);
    localparam logic [SW-1:0] DIV_MAX = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE - 1);
    typedef enum logic [1:0] {BARRIDO, REBOTE, ESPERA, LIBERA} estado_t;
    estado_t estado, estado_n;
    logic [3:0] s1, f, f_lat, f_lat_n, cod_lat, cod_lat_n, codigo_n;
    logic [SW-1:0] div, div_n;
    logic [DW-1:0] cnt, cnt_n;
    logic [1:0] col, col_n, fila;
    logic valida_n, presionada_n, libre;
    assign libre = &f;
    assign fila = !f[0] ? 2'd0 : !f[1] ? 2'd1 : !f[2] ? 2'd2 : 2'd3;
    assign Columnas = ~(4'b0001 << col);
    always_comb begin
        estado_n = estado;
        div_n = div;
        cnt_n = cnt;
        col_n = col;
        f_lat_n = f_lat;
        cod_lat_n = cod_lat;
        codigo_n = Codigo;
        valida_n = 1'b0;
        presionada_n = Presionada;
        case (estado)
            BARRIDO: begin
                div_n = (div == DIV_MAX) ? '0 : div + SW'(1);
                if (div == DIV_MAX) begin
                    if (libre) col_n = col + 2'd1;
                    else begin
                        cod_lat_n = {fila, col};
                        f_lat_n = f;
                        cnt_n = '0;
                        estado_n = REBOTE;
                    end
                end
            end
            // any change of the row pattern, even within the same column, restarts the scan
            REBOTE: begin
                if (f != f_lat) begin
                    estado_n = BARRIDO;
                    div_n = '0;
                end else if (cnt == DEB_MAX) begin
                    codigo_n = cod_lat;
                    valida_n = 1'b1;
                    presionada_n = 1'b1;
                    estado_n = ESPERA;
                end else cnt_n = cnt + DW'(1);
            end
            ESPERA: begin
                if (libre) begin
                    estado_n = LIBERA;
                    cnt_n = '0;
                end
            end
            LIBERA: begin
                if (!libre) estado_n = ESPERA;
                else if (cnt == DEB_MAX) begin
                    presionada_n = 1'b0;
                    div_n = '0;
                    col_n = col + 2'd1;
                    estado_n = BARRIDO;
                end else cnt_n = cnt + DW'(1);
            end
            default: estado_n = BARRIDO;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= BARRIDO;
            s1 <= 4'hF;
            f <= 4'hF;
            f_lat <= 4'hF;
            cod_lat <= 4'h0;
            div <= '0;
            cnt <= '0;
            col <= 2'd0;
            Codigo <= 4'h0;
            Valida <= 1'b0;
            Presionada <= 1'b0;
        end else begin
            estado <= estado_n;
            s1 <= Filas;
            f <= s1;
            f_lat <= f_lat_n;
            cod_lat <= cod_lat_n;
            div <= div_n;
            cnt <= cnt_n;
            col <= col_n;
            Codigo <= codigo_n;
            Valida <= valida_n;
            Presionada <= presionada_n;
        end
    end
endmodule
